// File: rtl/mux32_rr_arbiter.sv
// rtl/mux32_rr_arbiter.sv - round-robin arbiter sharing one 32:1 word mux among 32 lanes
// Captures the granted lane's word, presents it on valid/ready and acks the winner.

module mux32 #(
  parameter int N = 32
) (
  input  logic [32*N-1:0] d,
  input  logic [4:0]      s,
  output logic [N-1:0]    y
);

  assign y = d[s*N +: N];

endmodule

module mux32_rr_arbiter #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     req,
  input  logic [32*N-1:0] din,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [4:0]      out_id,
  output logic [4:0]      sel,
  output logic [31:0]     ack,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [4:0]   ptr;
  logic [4:0]   win;
  logic         any_req;
  logic [N-1:0] mux_y;

  assign any_req = |req;

  // Scan downward so the last hit is the lane closest to ptr (wrapping mod 32).
  always_comb begin
    win = ptr;
    for (int i = 31; i >= 0; i--) begin
      if (req[ptr + 5'(i)]) begin
        win = ptr + 5'(i);
      end
    end
  end

  assign sel = (state == HOLD) ? out_id : win;

  mux32 #(.N(N)) u_mux (
    .d (din),
    .s (sel),
    .y (mux_y)
  );

  always_comb begin
    state_next = state;
    ack        = '0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ack        = 32'd1 << out_id;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 5'd0;
      out_data <= '0;
      out_id   <= 5'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        out_id   <= win;
        out_data <= mux_y;
      end
      // The winner drops to lowest priority once its word is accepted.
      if (state == HOLD && out_ready) begin
        ptr <= out_id + 5'd1;
      end
    end
  end

endmodule
